seven_seg_scan_driver: RTL and testbench
========================================

Name: seven_seg_scan_driver

Overview:
- Consumer of the CEOUT clock-enable from the dynamic-lighting divider.
- Time-multiplexes NDIG hex digits onto one shared 7-segment bus with common anodes.
- Snapshots the display data once per frame so digits never tear mid-scan.
- Inserts a blanking gap between digits to suppress ghosting; runs on the board CLK (40 MHz).

Parameters:
NDIG, 4, number of digits scanned (2..8)
ON_TICKS, 3, CE ticks each digit is lit (>=1)
BLANK_TICKS, 1, CE ticks all anodes are off before each digit (0..15; 0 = no gap)

Ports:
CLK  in  1  system clock
RST  in  1  reset, synchronous, active-high
CE  in  1  clock enable from the divider; each CLK it is high counts one tick
DATA  in  4*NDIG  hex nibbles; [3:0] = digit 0 (least significant)
DP  in  NDIG  decimal point request per digit, active-high
EN  in  NDIG  digit enable per digit, active-high
LZB  in  1  leading-zero blanking enable
SEG  out  7  segments {g,f,e,d,c,b,a}, active-low
DPOUT  out  1  decimal point, active-low
AN  out  NDIG  anode select, active-low, at most one bit low
FRAME  out  1  one-CLK pulse when a new snapshot is taken

Behaviour:
- Synchronous active-high reset on CLK; RST wins over CE in the same cycle.
- Reset values:
  - AN = all 1, SEG = 7'h7F, DPOUT = 1, FRAME = 0.
  - Digit index idx = 0, tick counter cnt = 0, state = BLANK.
  - Shadow DATA/DP/EN = 0.
- Reset mid-scan returns to these values on the next CLK.
- All outputs are registered. They change on the CLK edge that samples CE = 1. Without CE, the state is frozen.
- States and transitions:
  - BLANK: AN all 1, SEG = 7'h7F, DPOUT = 1.
  - BLANK, on CE: if cnt == BLANK_TICKS-1 then go to SHOW and set cnt = 0; otherwise cnt += 1.
  - SHOW: AN[idx] = 0 and SEG/DPOUT are driven from shadow digit idx.
  - SHOW, on CE at cnt == ON_TICKS-1: idx advances (NDIG-1 wraps to 0) and cnt = 0.
    - BLANK_TICKS > 0: next state is BLANK.
    - BLANK_TICKS == 0: next state is SHOW for the new idx directly.
  - SHOW, on CE otherwise: cnt += 1.
- Snapshot:
  - Shadow registers load DATA/DP/EN on the CLK that enters SHOW with idx = 0 (from BLANK, or the SHOW->SHOW wrap).
  - FRAME = 1 for exactly that CLK.
  - The digit-0 outputs on that edge already use the new data.
  - The first frame after reset therefore shows fresh data.
- Digit masking:
  - A digit with EN = 0 still consumes its SHOW slot, so the duty cycle stays uniform.
  - During that slot AN stays all 1, SEG = 7'h7F, DPOUT = 1.
- Leading-zero blanking (LZB = 1):
  - Digit k is blanked if all shadow nibbles k..NDIG-1 are 0 and k != 0. Digit 0 is never blanked.
  - A blanked digit drives SEG = 7'h7F, but its DP still shows and AN is still asserted.
  - LZB is sampled live, not snapshotted.
- Hex decode, active-low {g..a}:
  - 0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78.
  - 8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E.
- CE held high continuously is legal: one tick per CLK.
- Frame period in CE ticks = NDIG*(ON_TICKS+BLANK_TICKS).

Decomposition:
- Package seven_seg_pkg holds:
  - the 16-entry hex->segment constant table;
  - the blank pattern 7'h7F;
  - the state encoding (BLANK, SHOW).
- One sub-module, hex_to_seg7: 4-bit nibble in, 7-bit active-low segments out, combinational, using the package table.

Test Plan:
(Defaults NDIG=4, ON_TICKS=3, BLANK_TICKS=1, CE pulsing one CLK in every 4, unless stated.)
1. Reset/snapshot: hold RST 5 CLK, then DATA=16'h12AF, DP=4'b0100, EN=4'hF, LZB=0 -> AN=4'hF and SEG=7'h7F until the first CE. On the 1st CE edge: AN=4'b1110, SEG=7'h0E, FRAME=1 for one CLK.
2. Scan order: continue test 1 -> after each 3 SHOW ticks, 1 BLANK tick with AN=4'hF. Sequence is AN 1110 (0E), 1101 (08), 1011 (24, DPOUT=0), 0111 (79). Wrap back to 1110 with FRAME=1, at 16 CE ticks per frame.
3. Tear-free: change DATA to 16'h0000 while digit 2 is lit -> digits 2 and 3 still show 2 and 1. New data appears only from the next FRAME.
4. LZB and EN: DATA=16'h0050, LZB=1, EN=4'b1110:
   - digits 3 and 2: AN asserted, SEG=7'h7F;
   - digit 1: SEG=7'h12;
   - digit 0: AN=4'hF for its whole 3-tick slot.
5. BLANK_TICKS=0, CE tied high -> no all-off cycle. AN changes every 3 CLK and FRAME pulses every 12 CLK.
6. Reset mid-SHOW on digit 2, asserted in the same cycle as CE -> next CLK: AN=4'hF, SEG=7'h7F, FRAME=0. Restart from digit 0 after BLANK.

Source files
------------

// File: rtl/seven_seg_pkg.sv
// rtl/seven_seg_pkg.sv - shared segment table, blank pattern and scan state encoding
package seven_seg_pkg;

    // All segments off, active-low {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Active-low {g..a} patterns; index 15 is listed first
    localparam logic [15:0][6:0] HEX_SEG = {
        7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
        7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
    };

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } scan_state_e;

endpackage

// File: rtl/hex_to_seg7.sv
// rtl/hex_to_seg7.sv - combinational hex nibble to active-low seven-segment decode
module hex_to_seg7
    import seven_seg_pkg::*;
(
    input  logic [3:0] nibble,
    output logic [6:0] seg
);

    assign seg = HEX_SEG[nibble];

endmodule

// File: rtl/seven_seg_scan_driver.sv
// rtl/seven_seg_scan_driver.sv - multiplexed common-anode hex display scanner with frame snapshot
module seven_seg_scan_driver
    import seven_seg_pkg::*;
#(
    parameter int NDIG        = 4,
    parameter int ON_TICKS    = 3,
    parameter int BLANK_TICKS = 1
) (
    input  logic              CLK,
    input  logic              RST,
    input  logic              CE,
    input  logic [4*NDIG-1:0] DATA,
    input  logic [NDIG-1:0]   DP,
    input  logic [NDIG-1:0]   EN,
    input  logic              LZB,
    output logic [6:0]        SEG,
    output logic              DPOUT,
    output logic [NDIG-1:0]   AN,
    output logic              FRAME
);

    localparam int IDX_W   = (NDIG > 1) ? $clog2(NDIG) : 1;
    localparam int CNT_MAX = (ON_TICKS > BLANK_TICKS) ? ON_TICKS : BLANK_TICKS;
    localparam int CNT_W   = (CNT_MAX > 1) ? $clog2(CNT_MAX) : 1;

    localparam logic [CNT_W-1:0] ON_LAST    = CNT_W'(ON_TICKS - 1);
    // With no blanking gap the reset BLANK state still lasts one tick
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'((BLANK_TICKS > 0) ? BLANK_TICKS - 1 : 0);
    localparam logic [IDX_W-1:0] IDX_LAST   = IDX_W'(NDIG - 1);

    scan_state_e        state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [4*NDIG-1:0]  data_sh_q, data_sh_d;
    logic [NDIG-1:0]    dp_sh_q, dp_sh_d;
    logic [NDIG-1:0]    en_sh_q, en_sh_d;
    logic [NDIG-1:0]    an_q, an_d;
    logic [6:0]         seg_q, seg_d;
    logic               dpout_q, dpout_d;
    logic               frame_q, frame_d;

    logic               snap;
    logic [NDIG-1:0]    lz_blank;
    logic               zero_run;
    logic [3:0]         nib_sel;
    logic [6:0]         seg_dec;

    // Scan sequencer: per-digit blank gap then lit slot, advancing only on CE
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        snap    = 1'b0;
        if (CE) begin
            unique case (state_q)
                ST_BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = ST_SHOW;
                        cnt_d   = '0;
                        snap    = (idx_q == '0);
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                ST_SHOW: begin
                    if (cnt_q == ON_LAST) begin
                        idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
                        cnt_d = '0;
                        if (BLANK_TICKS > 0) begin
                            state_d = ST_BLANK;
                        end else begin
                            state_d = ST_SHOW;
                            snap    = (idx_d == '0);
                        end
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
                default: begin
                    state_d = ST_BLANK;
                end
            endcase
        end
    end

    // Shadow copy of display inputs, refreshed only as digit 0 lights so a frame never tears
    always_comb begin
        data_sh_d = data_sh_q;
        dp_sh_d   = dp_sh_q;
        en_sh_d   = en_sh_q;
        if (snap) begin
            data_sh_d = DATA;
            dp_sh_d   = DP;
            en_sh_d   = EN;
        end
    end

    // Leading-zero map: digit k qualifies when it and every higher nibble are zero; digit 0 never does
    always_comb begin
        zero_run = 1'b1;
        lz_blank = '0;
        for (int k = NDIG - 1; k >= 1; k--) begin
            zero_run    = zero_run & (data_sh_d[4*k +: 4] == 4'h0);
            lz_blank[k] = zero_run;
        end
    end

    assign nib_sel = data_sh_d[{idx_d, 2'b00} +: 4];

    hex_to_seg7 u_hex_to_seg7 (
        .nibble (nib_sel),
        .seg    (seg_dec)
    );

    // Registered outputs for the state being entered, using post-snapshot shadow data
    always_comb begin
        an_d    = an_q;
        seg_d   = seg_q;
        dpout_d = dpout_q;
        frame_d = 1'b0;
        if (CE) begin
            frame_d = snap;
            an_d    = '1;
            seg_d   = SEG_BLANK;
            dpout_d = 1'b1;
            if (state_d == ST_SHOW && en_sh_d[idx_d]) begin
                an_d[idx_d] = 1'b0;
                seg_d       = (LZB && lz_blank[idx_d]) ? SEG_BLANK : seg_dec;
                dpout_d     = ~dp_sh_d[idx_d];
            end
        end
    end

    // State, shadow and output registers with synchronous reset
    always_ff @(posedge CLK) begin
        if (RST) begin
            state_q   <= ST_BLANK;
            idx_q     <= '0;
            cnt_q     <= '0;
            data_sh_q <= '0;
            dp_sh_q   <= '0;
            en_sh_q   <= '0;
            an_q      <= '1;
            seg_q     <= SEG_BLANK;
            dpout_q   <= 1'b1;
            frame_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            data_sh_q <= data_sh_d;
            dp_sh_q   <= dp_sh_d;
            en_sh_q   <= en_sh_d;
            an_q      <= an_d;
            seg_q     <= seg_d;
            dpout_q   <= dpout_d;
            frame_q   <= frame_d;
        end
    end

    assign AN    = an_q;
    assign SEG   = seg_q;
    assign DPOUT = dpout_q;
    assign FRAME = frame_q;

endmodule

// File: tb/tb_seven_seg_scan_driver.sv
// tb/tb_seven_seg_scan_driver.sv - scoreboard bench for the seven-segment scan driver
`timescale 1ns/1ps
module tb_seven_seg_scan_driver;

    localparam int NDIG = 4;
    localparam int ON   = 3;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dpo;
        logic       fr;
    } obs_t;

    typedef struct packed {
        int         t;
        logic [15:0] d;
        logic [3:0]  dp;
        logic [3:0]  en;
        obs_t        o;
    } mdl_t;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        ce_a = 1'b0;
    logic [15:0] data = '0;
    logic [3:0]  dp = '0;
    logic [3:0]  en = '0;
    logic        lzb = 1'b0;

    logic [6:0]  seg_a, seg_b;
    logic        dpo_a, dpo_b, fr_a, fr_b;
    logic [3:0]  an_a, an_b;

    int checks = 0;
    int errors = 0;

    obs_t qa[$];
    obs_t qb[$];
    mdl_t ma, mb;

    always #12 clk = ~clk;

    seven_seg_scan_driver #(.NDIG(4), .ON_TICKS(3), .BLANK_TICKS(1)) dut_a (
        .CLK(clk), .RST(rst), .CE(ce_a), .DATA(data), .DP(dp), .EN(en), .LZB(lzb),
        .SEG(seg_a), .DPOUT(dpo_a), .AN(an_a), .FRAME(fr_a)
    );

    seven_seg_scan_driver #(.NDIG(4), .ON_TICKS(3), .BLANK_TICKS(0)) dut_b (
        .CLK(clk), .RST(rst), .CE(1'b1), .DATA(data), .DP(dp), .EN(en), .LZB(lzb),
        .SEG(seg_b), .DPOUT(dpo_b), .AN(an_b), .FRAME(fr_b)
    );

    function automatic logic [6:0] ref_seg(input logic [3:0] v);
        logic [6:0] tbl [16];
        tbl = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return tbl[v];
    endfunction

    // Timeline model: position within the frame follows from the tick count since reset
    function automatic mdl_t model_step(input mdl_t m, input int bl, input logic r, input logic c,
                                        input logic [15:0] din, input logic [3:0] dpin,
                                        input logic [3:0] enin, input logic lz);
        mdl_t n;
        int slot, s, dig, off;
        n = m;
        n.o.fr = 1'b0;
        if (r) begin
            n.t  = 0;
            n.d  = '0;
            n.dp = '0;
            n.en = '0;
            n.o  = {4'hF, 7'h7F, 1'b1, 1'b0};
        end else if (c) begin
            n.t  = m.t + 1;
            slot = ON + bl;
            s    = (bl == 0) ? (n.t - 1) % (NDIG * slot) : n.t % (NDIG * slot);
            dig  = s / slot;
            off  = s % slot;
            if (dig == 0 && off == bl) begin
                n.d    = din;
                n.dp   = dpin;
                n.en   = enin;
                n.o.fr = 1'b1;
            end
            n.o.an  = 4'hF;
            n.o.seg = 7'h7F;
            n.o.dpo = 1'b1;
            if (off >= bl && n.en[dig]) begin
                n.o.an[dig] = 1'b0;
                n.o.seg = (lz && dig != 0 && (n.d >> (4 * dig)) == 16'h0) ? 7'h7F
                                                                          : ref_seg(n.d[4*dig +: 4]);
                n.o.dpo = ~n.dp[dig];
            end
        end
        return n;
    endfunction

    task automatic check(input string name, input obs_t act, input obs_t exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s @%0t: got an=%b seg=%h dp=%b frame=%b, expected an=%b seg=%h dp=%b frame=%b",
                     name, $time, act.an, act.seg, act.dpo, act.fr, exp.an, exp.seg, exp.dpo, exp.fr);
        end
    endtask

    // One clock of stimulus; the expected result of that edge goes to each scoreboard
    task automatic cyc(input logic r, input logic c);
        rst  = r;
        ce_a = c;
        @(posedge clk);
        ma = model_step(ma, 1, r, c, data, dp, en, lzb);
        qa.push_back(ma.o);
        mb = model_step(mb, 0, r, 1'b1, data, dp, en, lzb);
        qb.push_back(mb.o);
        #1;
    endtask

    task automatic ticks(input int n);
        repeat (n) begin
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b0);
            cyc(1'b0, 1'b1);
        end
    endtask

    always @(negedge clk) begin
        obs_t e;
        if (qa.size() > 0) begin
            e = qa.pop_front();
            check("dut_a_outputs", {an_a, seg_a, dpo_a, fr_a}, e);
        end
        if (qb.size() > 0) begin
            e = qb.pop_front();
            check("dut_b_outputs", {an_b, seg_b, dpo_b, fr_b}, e);
        end
    end

    initial begin
        data = 16'h12AF;
        dp   = 4'b0100;
        en   = 4'hF;
        lzb  = 1'b0;
        repeat (5) cyc(1'b1, 1'b0);
        ticks(36);

        repeat (2) cyc(1'b1, 1'b0);
        ticks(10);
        data = 16'h0000;
        ticks(12);

        data = 16'h0050;
        lzb  = 1'b1;
        en   = 4'b1110;
        ticks(20);

        data = 16'h12AF;
        en   = 4'hF;
        lzb  = 1'b0;
        repeat (2) cyc(1'b1, 1'b0);
        ticks(9);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b0, 1'b0);
        cyc(1'b1, 1'b1);
        ticks(8);

        repeat (1500) begin
            data = 16'($urandom) >> (4 * $urandom_range(0, 4));
            dp   = 4'($urandom);
            en   = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
            lzb  = 1'($urandom);
            cyc(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) == 0));
        end

        @(negedge clk);
        #1;
        checks++;
        if (qa.size() != 0 || qb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: got %0d/%0d pending, expected 0/0", qa.size(), qb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
